// File: rtl/eab_addr_seq.sv
// eab_addr_seq: LC-3 effective-address and memory-access sequencer between the control FSM and datapath.
// Define MEM_TIMEOUT_EN to abort memory waits after TIMEOUT_CYCLES cycles with an err pulse.
module eab_addr_seq #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       irBit11,
    input  logic       brTaken,
    input  logic       memRdy,
    output logic       selEAB1,
    output logic [1:0] selEAB2,
    output logic       ldMAR,
    output logic       marSrc,
    output logic       memReq,
    output logic       memWE,
    output logic       ldMDR,
    output logic       ldReg,
    output logic       ldPC,
    output logic       ldR7,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, EA, RD, IND, WB, WR, DONE} state_t;

    localparam logic [3:0] OP_BR = 4'h0, OP_LD = 4'h2, OP_ST = 4'h3, OP_JSR = 4'h4,
                           OP_LDR = 4'h6, OP_STR = 4'h7, OP_LDI = 4'hA, OP_STI = 4'hB,
                           OP_JMP = 4'hC, OP_LEA = 4'hE;

    state_t     state, nxt;
    logic [3:0] op;
    logic       ir11, ind, tmo, handled;

    if (TO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_to_w_check
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    assign handled = opcode inside {OP_BR, OP_LD, OP_ST, OP_JSR, OP_LDR, OP_STR,
                                    OP_LDI, OP_STI, OP_JMP, OP_LEA};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= 4'h0;
            ir11  <= 1'b0;
            ind   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                op   <= opcode;
                ir11 <= irBit11;
            end
            ind <= (state == IND) | (ind & (state != DONE));
        end
    end

    always_comb begin
        nxt     = state;
        selEAB1 = 1'b0;
        selEAB2 = 2'd0;
        ldMAR   = 1'b0;
        marSrc  = 1'b0;
        memReq  = 1'b0;
        memWE   = 1'b0;
        ldMDR   = 1'b0;
        ldReg   = 1'b0;
        ldPC    = 1'b0;
        ldR7    = 1'b0;
        done    = 1'b0;
        busy    = state != IDLE;
        if (state != IDLE) begin
            selEAB1 = (op inside {OP_LDR, OP_STR, OP_JMP}) || (op == OP_JSR && !ir11);
            selEAB2 = (op inside {OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA}) ? 2'd2 :
                      (op inside {OP_LDR, OP_STR})                               ? 2'd1 :
                      (op == OP_JSR && ir11)                                     ? 2'd3 : 2'd0;
        end
        case (state)
            IDLE: if (start) nxt = handled ? EA : DONE;
            EA: begin
                ldReg = op == OP_LEA;
                ldPC  = (op == OP_BR && brTaken) || (op inside {OP_JMP, OP_JSR});
                ldR7  = op == OP_JSR;
                ldMAR = op inside {OP_LD, OP_LDR, OP_LDI, OP_STI, OP_ST, OP_STR};
                nxt   = (op inside {OP_ST, OP_STR}) ? WR : ldMAR ? RD : DONE;
            end
            RD: begin
                memReq = 1'b1;
                ldMDR  = memRdy;
                // first pass of an indirect access fetches the pointer, not the data
                nxt    = memRdy ? (((op inside {OP_LDI, OP_STI}) && !ind) ? IND :
                                   (op == OP_STI) ? WR : WB) :
                         tmo ? DONE : RD;
            end
            IND: begin
                ldMAR  = 1'b1;
                marSrc = 1'b1;
                nxt    = (op == OP_STI) ? WR : RD;
            end
            WB: begin
                ldReg = 1'b1;
                nxt   = DONE;
            end
            WR: begin
                memReq = 1'b1;
                memWE  = 1'b1;
                nxt    = (memRdy || tmo) ? DONE : WR;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] cnt;
    logic            to_hit;

    // a memRdy arriving on the last allowed cycle still completes the access
    assign tmo = (state == RD || state == WR) && !memRdy && cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign err = state == DONE && to_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            to_hit <= 1'b0;
        end else begin
            cnt    <= (state == RD || state == WR) ? cnt + TO_W'(1) : '0;
            to_hit <= tmo | (to_hit & (state != DONE));
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_eab_addr_seq.sv
// tb_eab_addr_seq: table-driven scoreboard bench for eab_addr_seq, plus reset-abort and timeout sequences.
module tb_eab_addr_seq;
    logic       clock = 1'b0, reset = 1'b1, start = 1'b0, irBit11 = 1'b0, brTaken = 1'b0, memRdy = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       selEAB1, ldMAR, marSrc, memReq, memWE, ldMDR, ldReg, ldPC, ldR7, busy, done, err;
    logic [1:0] selEAB2;

    eab_addr_seq dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode), .irBit11(irBit11),
        .brTaken(brTaken), .memRdy(memRdy), .selEAB1(selEAB1), .selEAB2(selEAB2),
        .ldMAR(ldMAR), .marSrc(marSrc), .memReq(memReq), .memWE(memWE), .ldMDR(ldMDR),
        .ldReg(ldReg), .ldPC(ldPC), .ldR7(ldR7), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] op;
        logic ir11, br, poke;
        int dly, lat, s1, s2, mar, mdr, rg, pc, r7, req, we, src, er;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0, fails = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({selEAB1, selEAB2, ldMAR, marSrc, memReq, memWE, ldMDR, ldReg, ldPC, ldR7, busy, done, err});
    endfunction

    function automatic void add(input logic [3:0] op, input logic ir11, input logic br, input logic poke,
                                input int dly, input int lat, input int s1, input int s2, input int mar,
                                input int mdr, input int rg, input int pc, input int r7, input int req,
                                input int we, input int src, input int er);
        vec_t v;
        v.op = op; v.ir11 = ir11; v.br = br; v.poke = poke; v.dly = dly; v.lat = lat;
        v.s1 = s1; v.s2 = s2; v.mar = mar; v.mdr = mdr; v.rg = rg; v.pc = pc; v.r7 = r7;
        v.req = req; v.we = we; v.src = src; v.er = er;
        tbl.push_back(v);
    endfunction

    task automatic run(input vec_t v);
        int cyc = 1, wt = 0, lat = -1, s1 = -1, s2 = -1;
        int mar = 0, mdr = 0, rg = 0, pc = 0, r7 = 0, req = 0, we = 0, src = 0, bz = 0, er = 0;
        string tag;
        vec_t e;
        tag = $sformatf("op%h_d%0d", v.op, v.dly);
        @(negedge clock);
        opcode = v.op; irBit11 = v.ir11; brTaken = v.br; start = 1'b1; memRdy = 1'b0;
        sb.push_back(v);
        @(negedge clock);
        while (lat < 0 && cyc < 60) begin
            start  = v.poke && cyc == 2;
            opcode = start ? 4'hE : 4'h0;
            memRdy = memReq && wt == v.dly;
            wt     = (memReq && !memRdy) ? wt + 1 : 0;
            #1;
            if (cyc == 1) begin
                s1 = int'(selEAB1);
                s2 = int'(selEAB2);
            end
            mar += int'(ldMAR); mdr += int'(ldMDR); rg += int'(ldReg); pc += int'(ldPC);
            r7 += int'(ldR7); req += int'(memReq); we += int'(memReq & memWE);
            src += int'(ldMAR & marSrc); bz += int'(busy); er += int'(err);
            if (done) lat = cyc;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0; memRdy = 1'b0;
        #1;
        check({tag, "_idle_after"}, int'(busy), 0);
        if (lat < 0) begin
            check({tag, "_done_seen"}, 0, 1);
            e = sb.pop_front();
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            if (e.lat > 1) begin
                check({tag, "_selEAB1"}, s1, e.s1);
                check({tag, "_selEAB2"}, s2, e.s2);
            end
            check({tag, "_ldMAR"}, mar, e.mar);
            check({tag, "_ldMDR"}, mdr, e.mdr);
            check({tag, "_ldReg"}, rg, e.rg);
            check({tag, "_ldPC"}, pc, e.pc);
            check({tag, "_ldR7"}, r7, e.r7);
            check({tag, "_memReq"}, req, e.req);
            check({tag, "_memWE"}, we, e.we);
            check({tag, "_marSrc"}, src, e.src);
            check({tag, "_busy"}, bz, e.lat);
            check({tag, "_err"}, er, e.er);
        end
    endtask

    initial begin
        //   op   ir br pk dly lat s1 s2 mar mdr rg pc r7 req we src er
        add(4'h2, 0, 0, 0, 0,  4, 0, 2, 1, 1, 1, 0, 0, 1, 0, 0, 0);
        add(4'h2, 0, 0, 1, 0,  4, 0, 2, 1, 1, 1, 0, 0, 1, 0, 0, 0);
        add(4'h2, 0, 0, 0, 2,  6, 0, 2, 1, 1, 1, 0, 0, 3, 0, 0, 0);
        add(4'h3, 0, 0, 0, 0,  3, 0, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add(4'h6, 0, 0, 0, 1,  5, 1, 1, 1, 1, 1, 0, 0, 2, 0, 0, 0);
        add(4'h7, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add(4'hA, 0, 0, 0, 0,  6, 0, 2, 2, 2, 1, 0, 0, 2, 0, 1, 0);
        add(4'hA, 0, 0, 0, 1,  8, 0, 2, 2, 2, 1, 0, 0, 4, 0, 1, 0);
        add(4'hB, 0, 0, 0, 3, 11, 0, 2, 2, 1, 0, 0, 0, 8, 4, 1, 0);
        add(4'hB, 0, 0, 0, 0,  5, 0, 2, 2, 1, 0, 0, 0, 2, 1, 1, 0);
        add(4'h0, 0, 0, 0, 0,  2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'h0, 0, 1, 0, 0,  2, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4'hC, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4'h4, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(4'h4, 1, 0, 0, 0,  2, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(4'hE, 0, 0, 0, 0,  2, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4'h1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'hF, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'hD, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_TIMEOUT_EN
        add(4'h2, 0, 0, 0, 1000, 18, 0, 2, 1, 0, 0, 0, 0, 16, 0, 0, 1);
`endif

        #12;
        check("reset_outputs", outs(), 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // reset during the RD phase of an LDR must kill every strobe at once
        @(negedge clock);
        opcode = 4'h6; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #1;
        check("ldr_rd_memReq", int'(memReq), 1);
        reset = 1'b1;
        #1;
        check("abort_outputs", outs(), 0);
        @(negedge clock);
        #1;
        check("abort_held", outs(), 0);
        reset = 1'b0;
        run(tbl[15]);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/eab_addr_seq.md
Name: eab_addr_seq

Overview:
- Multicycle sequencer for LC-3 effective-address and memory-access phases.
- Drives EAB operand selects (selEAB1: 0=PC/1=Ra; selEAB2: 0=zero, 1=sext IR[5:0], 2=sext IR[8:0], 3=sext IR[10:0]).
- Steps MAR/MDR loads, memory request handshake and writeback strobes for BR, LD, ST, JSR/JSRR, LDR, STR, LDI, STI, JMP and LEA.
- Sits between the main control FSM (start/done) and the datapath/memory interface.

Parameters:
- TIMEOUT_CYCLES, 16: memory wait limit in cycles. Used only with MEM_TIMEOUT_EN.
- TO_W, 5: width of the timeout counter. Must be at least clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; returns block to IDLE
- start  input  1  begin sequence; sampled only in IDLE
- opcode  input  4  IR[15:12], latched at start
- irBit11  input  1  IR[11], latched at start; JSR(1) vs JSRR(0)
- brTaken  input  1  NZP match result, sampled in EA state
- memRdy  input  1  memory completes the current request
- selEAB1  output  1  EAB base select
- selEAB2  output  2  EAB offset select
- ldMAR  output  1  load MAR
- marSrc  output  1  MAR source: 0=EAB, 1=MDR (indirect)
- memReq  output  1  memory request
- memWE  output  1  1=write, valid while memReq=1
- ldMDR  output  1  load MDR from memory
- ldReg  output  1  write DR (LEA: EAB value; loads: MDR)
- ldPC  output  1  load PC from EAB
- ldR7  output  1  save PC to R7 (JSR/JSRR)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse coincident with done on timeout

Behaviour:
- Reset: state=IDLE; all outputs 0; latched opcode/irBit11 cleared.
- Reset mid-operation aborts at once: no further strobes, memReq drops asynchronously.
- States: IDLE, EA, RD, IND, WB, WR, DONE.
- Outputs are decoded from the registered state and the latched opcode. Strobes are one cycle wide except memReq/memWE.
- Select decode, held constant from EA through DONE; 0/0 in IDLE:
  - BR, LD, ST, LDI, STI, LEA: selEAB1=0, selEAB2=2.
  - LDR, STR: selEAB1=1, selEAB2=1.
  - JSR: 0/3.
  - JSRR, JMP: 1/0.
- IDLE:
  - start=1 with a handled opcode: latch opcode/irBit11, go to EA.
  - start=1 with an unhandled opcode (ADD, AND, NOT, RTI, TRAP, 1101): go to DONE with no strobes.
- EA:
  - LEA: ldReg=1, then DONE.
  - BR: ldPC=brTaken, then DONE.
  - JMP: ldPC=1, then DONE.
  - JSR/JSRR: ldPC=1 and ldR7=1, then DONE.
  - LD, LDR, LDI, STI: ldMAR=1, marSrc=0, then RD.
  - ST, STR: ldMAR=1, marSrc=0, then WR.
- RD: memReq=1, memWE=0; hold until memRdy. In the memRdy cycle:
  - ldMDR=1.
  - Next state is IND if LDI/STI and the indirect flag is clear; WR for STI second pass; otherwise WB.
- IND: ldMAR=1, marSrc=1; set the indirect flag.
  - LDI: go to RD.
  - STI: go to WR.
- WB: ldReg=1, then DONE.
- WR: memReq=1, memWE=1; hold until memRdy, then DONE.
- DONE: done=1, clear the indirect flag, then IDLE. A new start is accepted no earlier than the cycle after DONE.
- start while busy is ignored. memRdy outside RD/WR is ignored.
- Latency, start seen at cycle 0, memRdy on the first request cycle:
  - LEA, BR, JMP, JSR: done at cycle 2.
  - LD/LDR: done at cycle 4.
  - ST/STR: done at cycle 3.
  - LDI: done at cycle 6.
  - STI: done at cycle 5.
  - Each extra memory wait cycle adds 1.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - Counter resets on entry to RD/WR and increments each cycle without memRdy.
  - When it reaches TIMEOUT_CYCLES: memReq drops, no ldMDR/ldReg, go to DONE with err=1.
  - memRdy in the same cycle as the limit wins; the access completes normally.
- When undefined: waits indefinitely, err tied 0, no counter logic.

Test Plan:
- LD (opcode 0010), memRdy high immediately:
  - Cycle 1: selEAB1=0, selEAB2=2, ldMAR.
  - Cycle 2: memReq, memWE=0, ldMDR.
  - Cycle 3: ldReg.
  - Cycle 4: done.
- STI (1011), memRdy delayed 3 cycles per access:
  - Sequence EA, RD (x4), IND (marSrc=1, ldMAR), WR (x4, memWE=1), DONE.
  - done at cycle 11.
- BR (0000) with brTaken=0, then with brTaken=1:
  - ldPC=0 vs ldPC=1 in cycle 1.
  - done at cycle 2 in both cases.
- JSRR (0100, irBit11=0):
  - Cycle 1: selEAB1=1, selEAB2=0, ldPC=1, ldR7=1.
  - Repeat with irBit11=1: selEAB2=3.
- Reset asserted during RD of an LDR:
  - Outputs 0 immediately.
  - Next start with LEA (1110) gives ldReg at cycle 1, done at cycle 2.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, memRdy held low on LD:
  - memReq high exactly 16 cycles.
  - done=1 and err=1 together; ldMDR and ldReg never assert.
